// File: rtl/usb_pkt_pkg.sv
// Shared USB packet definitions: PID codes and classes, decoder states,
// status codes, and CRC5/CRC16 constants plus a byte-wide CRC5 helper.
package usb_pkt_pkg;

  // Token PIDs
  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SOF   = 4'h5;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_PING  = 4'h4;
  // Data PIDs
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_DATA2 = 4'h7;
  localparam logic [3:0] PID_MDATA = 4'hF;
  // Handshake PIDs
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;
  localparam logic [3:0] PID_NYET  = 4'h6;

  typedef enum logic [1:0] {
    CLS_TOKEN, CLS_DATA, CLS_HSK, CLS_BAD
  } pid_cls_e;

  typedef enum logic [2:0] {
    ST_OK  = 3'd0,
    ST_PID = 3'd1,
    ST_CRC = 3'd2,
    ST_FMT = 3'd3,
    ST_PHY = 3'd4,
    ST_OVF = 3'd5
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE, S_TOKEN, S_DATA, S_HSK, S_DISCARD
  } dec_state_e;

  // Polynomials in shift-left form (implicit top term), LSB of each byte first.
  localparam logic [4:0]  CRC5_POLY   = 5'b00101;
  localparam logic [4:0]  CRC5_INIT   = 5'h1F;
  localparam logic [4:0]  CRC5_RESID  = 5'b01100;
  localparam logic [15:0] CRC16_POLY  = 16'h8005;
  localparam logic [15:0] CRC16_INIT  = 16'hFFFF;
  localparam logic [15:0] CRC16_RESID = 16'h800D;

  function automatic pid_cls_e pid_class(input logic [3:0] pid);
    case (pid)
      PID_OUT, PID_IN, PID_SOF, PID_SETUP, PID_PING:    return CLS_TOKEN;
      PID_DATA0, PID_DATA1, PID_DATA2, PID_MDATA:       return CLS_DATA;
      PID_ACK, PID_NAK, PID_STALL, PID_NYET:            return CLS_HSK;
      default:                                          return CLS_BAD;
    endcase
  endfunction

  // Advance CRC5 by one byte, bit 0 first.
  function automatic logic [4:0] crc5_byte(input logic [4:0] crc, input logic [7:0] b);
    logic [4:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[4] ^ b[i]) c = {c[3:0], 1'b0} ^ CRC5_POLY;
      else             c = {c[3:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/rx_pkt_dec_if.sv
// PHY-facing strobes and decoded-packet outputs of the receive decoder.
// slave: the decoder; master: the PHY / SIE side driving and observing it.
interface rx_pkt_dec_if;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_err_i;
  logic        rx_ready_i;
  logic [3:0]  pid_o;
  logic [10:0] token_o;
  logic [7:0]  data_o;
  logic        data_valid_o;
  logic        pkt_end_o;
  logic [2:0]  status_o;

  modport slave (
    input  rx_data_i, rx_valid_i, rx_err_i, rx_ready_i,
    output pid_o, token_o, data_o, data_valid_o, pkt_end_o, status_o
  );

  modport master (
    output rx_data_i, rx_valid_i, rx_err_i, rx_ready_i,
    input  pid_o, token_o, data_o, data_valid_o, pkt_end_o, status_o
  );
endinterface

// File: rtl/rx_crc16.sv
// Byte-wide USB CRC16 accumulator. init_i reloads the seed and wins over
// en_i; en_i folds data_i in, LSB first.
module rx_crc16
  import usb_pkt_pkg::*;
(
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q, crc_d;

  // next CRC after folding in one byte
  always_comb begin
    crc_d = crc_q;
    for (int i = 0; i < 8; i++) begin
      if (crc_d[15] ^ data_i[i]) crc_d = {crc_d[14:0], 1'b0} ^ CRC16_POLY;
      else                       crc_d = {crc_d[14:0], 1'b0};
    end
  end

  // CRC register: seed on init, accumulate on enable
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)     crc_q <= CRC16_INIT;
    else if (init_i) crc_q <= CRC16_INIT;
    else if (en_i)   crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/rx_pkt_dec.sv
// USB full-speed receive packet decoder: PID check, token/data/handshake
// format, CRC5/CRC16, CRC-stripped payload stream, one status per packet.
// Optional payload length limit when RX_PKT_DEC_LEN_CHECK_EN is defined.
module rx_pkt_dec
  import usb_pkt_pkg::*;
#(
  parameter int MAX_PAYLOAD = 64
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  rx_pkt_dec_if.slave    bus
);

  // PHY strobe decode; an error qualifier always means abort
  logic byte_ev, abort_ev, eop_ev;
  assign abort_ev = bus.rx_ready_i &  bus.rx_err_i;
  assign byte_ev  = bus.rx_ready_i & ~bus.rx_err_i &  bus.rx_valid_i;
  assign eop_ev   = bus.rx_ready_i & ~bus.rx_err_i & ~bus.rx_valid_i;

  dec_state_e       state_q;
  logic [3:0]       pid_q;
  logic [10:0]      token_q;
  logic [7:0]       data_q;
  logic             dv_q;
  logic             end_q;
  status_e          status_q;
  status_e          lat_q;     // first error seen, reported at EOP from DISCARD
  logic [1:0]       cnt_q;     // bytes after PID, saturating at 2
  logic [1:0][7:0]  dly_q;     // [0] newest, [1] oldest: hides the CRC bytes
  logic [4:0]       crc5_q;
  logic [15:0]      crc16;
`ifdef RX_PKT_DEC_LEN_CHECK_EN
  localparam logic [10:0] MAX_LEN = 11'(MAX_PAYLOAD);
  logic [10:0]      len_q;     // payload bytes forwarded so far
`endif

  // CRC16 is seeded every idle cycle and fed only with DATA-state bytes
  rx_crc16 u_crc16 (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .init_i (state_q == S_IDLE),
    .en_i   (byte_ev && state_q == S_DATA),
    .data_i (bus.rx_data_i),
    .crc_o  (crc16)
  );

  // decoder FSM with registered outputs
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      pid_q    <= 4'h0;
      token_q  <= '0;
      data_q   <= '0;
      dv_q     <= 1'b0;
      end_q    <= 1'b0;
      status_q <= ST_OK;
      lat_q    <= ST_OK;
      cnt_q    <= '0;
      dly_q    <= '0;
      crc5_q   <= CRC5_INIT;
`ifdef RX_PKT_DEC_LEN_CHECK_EN
      len_q    <= '0;
`endif
    end else begin
      dv_q  <= 1'b0;
      end_q <= 1'b0;
      if (abort_ev) begin
        end_q    <= 1'b1;
        status_q <= ST_PHY;
        state_q  <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (byte_ev) begin
              cnt_q  <= '0;
              crc5_q <= CRC5_INIT;
`ifdef RX_PKT_DEC_LEN_CHECK_EN
              len_q  <= '0;
`endif
              if (bus.rx_data_i[7:4] != ~bus.rx_data_i[3:0]) begin
                lat_q   <= ST_PID;
                state_q <= S_DISCARD;
              end else begin
                pid_q <= bus.rx_data_i[3:0];
                case (pid_class(bus.rx_data_i[3:0]))
                  CLS_TOKEN: state_q <= S_TOKEN;
                  CLS_DATA:  state_q <= S_DATA;
                  CLS_HSK:   state_q <= S_HSK;
                  default: begin
                    lat_q   <= ST_FMT;
                    state_q <= S_DISCARD;
                  end
                endcase
              end
            end else if (eop_ev) begin
              end_q    <= 1'b1;
              status_q <= ST_FMT;
            end
          end

          S_TOKEN: begin
            if (byte_ev) begin
              crc5_q <= crc5_byte(crc5_q, bus.rx_data_i);
              if (cnt_q == 2'd0) begin
                token_q[7:0] <= bus.rx_data_i;
                cnt_q        <= 2'd1;
              end else if (cnt_q == 2'd1) begin
                token_q[10:8] <= bus.rx_data_i[2:0];
                cnt_q         <= 2'd2;
              end else begin
                lat_q   <= ST_FMT;
                state_q <= S_DISCARD;
              end
            end else if (eop_ev) begin
              end_q    <= 1'b1;
              state_q  <= S_IDLE;
              status_q <= (cnt_q != 2'd2)        ? ST_FMT :
                          (crc5_q != CRC5_RESID) ? ST_CRC : ST_OK;
            end
          end

          S_DATA: begin
            if (byte_ev) begin
              dly_q[0] <= bus.rx_data_i;
              dly_q[1] <= dly_q[0];
              if (cnt_q == 2'd2) begin
`ifdef RX_PKT_DEC_LEN_CHECK_EN
                if (len_q == MAX_LEN) begin
                  lat_q   <= ST_OVF;
                  state_q <= S_DISCARD;
                end else begin
                  data_q <= dly_q[1];
                  dv_q   <= 1'b1;
                  len_q  <= len_q + 11'd1;
                end
`else
                data_q <= dly_q[1];
                dv_q   <= 1'b1;
`endif
              end else begin
                cnt_q <= cnt_q + 2'd1;
              end
            end else if (eop_ev) begin
              end_q    <= 1'b1;
              state_q  <= S_IDLE;
              status_q <= (cnt_q != 2'd2)        ? ST_FMT :
                          (crc16 != CRC16_RESID) ? ST_CRC : ST_OK;
            end
          end

          S_HSK: begin
            if (byte_ev) begin
              lat_q   <= ST_FMT;
              state_q <= S_DISCARD;
            end else if (eop_ev) begin
              end_q    <= 1'b1;
              status_q <= ST_OK;
              state_q  <= S_IDLE;
            end
          end

          S_DISCARD: begin
            if (eop_ev) begin
              end_q    <= 1'b1;
              status_q <= lat_q;
              state_q  <= S_IDLE;
            end
          end

          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.pid_o        = pid_q;
  assign bus.token_o      = token_q;
  assign bus.data_o       = data_q;
  assign bus.data_valid_o = dv_q;
  assign bus.pkt_end_o    = end_q;
  assign bus.status_o     = status_q;

endmodule

// File: doc/rx_pkt_dec.md
# rx_pkt_dec

USB 2.0 full-speed receive packet decoder, directly downstream of the receive PHY and upstream of the SIE endpoint logic. It consumes the PHY's byte/EOP/error strobes and checks PID integrity, packet format, CRC5 (tokens) and CRC16 (data). It emits decoded token fields, a CRC-stripped data byte stream, and one end-of-packet status strobe per packet.

## Interface
- MAX_PAYLOAD, 64: maximum data payload bytes; used only with the length check (see Configuration).
- clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- rx_data_i  in  8  PHY byte, LSB first on the bus.
- rx_valid_i  in  1  PHY valid qualifier.
- rx_err_i  in  1  PHY error qualifier.
- rx_ready_i  in  1  one-cycle PHY strobe.
  - valid & ready: byte.
  - err & ready: abort.
  - !valid & !err & ready: EOP.
- pid_o  out  4  PID of the current/last packet; reset 4'h0.
- token_o  out  11  token payload; addr = [6:0], endp = [10:7], frame number for SOF; reset 0.
- data_o  out  8  payload byte; reset 0.
- data_valid_o  out  1  one-cycle payload strobe; reset 0.
- pkt_end_o  out  1  one-cycle end-of-packet strobe; reset 0.
- status_o  out  3  qualifies pkt_end_o; reset 0.
  - 0 OK.
  - 1 PID check.
  - 2 CRC.
  - 3 format.
  - 4 PHY error.
  - 5 overflow.

## Operation
- PID classes:
  - Token: OUT 1, IN 9, SOF 5, SETUP D, PING 4.
  - Data: DATA0 3, DATA1 B, DATA2 7, MDATA F.
  - Handshake: ACK 2, NAK A, STALL E, NYET 6.
  - Any other PID (0, 8, C) is a format error.
- FSM states: IDLE, TOKEN, DATA, HSK, DISCARD.
- IDLE:
  - First byte checks byte[7:4] == ~byte[3:0]; on failure -> DISCARD with status 1.
  - On pass: pid_o <= byte[3:0], then -> TOKEN/DATA/HSK by class.
- TOKEN:
  - Exactly 2 bytes are expected.
  - CRC5 (x^5+x^2+1, init 5'h1F) runs over all 16 bits, LSB first; residual must be 5'b01100.
  - token_o loads from the bytes as they arrive.
- DATA:
  - CRC16 (0x8005, init 16'hFFFF) runs over all bytes including the CRC bytes; residual must be 16'h800D.
  - Bytes pass through a 2-entry delay so the two CRC bytes are never emitted.
  - data_valid_o fires when byte n+2 arrives and carries byte n.
- HSK: any byte after the PID is a format error.
- DISCARD: ignore bytes until EOP or abort, then report the latched status.
- EOP handling:
  - TOKEN with byte count != 2 -> status 3.
  - DATA with < 2 bytes after the PID -> status 3.
  - CRC mismatch -> status 2.
  - Otherwise status 0.
  - pkt_end_o fires; -> IDLE.
- EOP while in IDLE (no PID received) -> pkt_end_o, status 3.
- PHY abort in any state -> pkt_end_o, status 4, -> IDLE; an earlier latched status is overridden.
- Payload bytes may already be forwarded before a CRC failure. The consumer commits data only on pkt_end_o with status 0.
- When several errors occur in one packet, the first detected error is reported; PHY abort is the only override.

## Timing
- Every output is registered.
- pkt_end_o and status_o are valid the cycle after the EOP or abort rx_ready_i.
- data_valid_o is asserted the cycle after the rx_ready_i of the byte that pushes it out.
- pid_o updates the cycle after the PID byte strobe.
- token_o is stable from the last token byte until the next token.
- No backpressure. rx_ready_i is accepted on every cycle, including back-to-back cycles.
- Exactly one pkt_end_o per packet. A new PID may arrive the cycle after pkt_end_o.
- Async reset mid-packet: FSM -> IDLE, CRC state, counters and delay line cleared, all outputs return to their reset values, no strobe is emitted.

## Configuration
- RX_PKT_DEC_LEN_CHECK_EN defined:
  - An 11-bit payload counter is built.
  - Data payload bytes beyond MAX_PAYLOAD (excluding the CRC bytes) -> DISCARD with status 5.
  - Overflowing bytes are not forwarded.
- RX_PKT_DEC_LEN_CHECK_EN undefined:
  - No counter is built; payload length is unlimited.
  - Status 5 is never produced.

## Structure
- Shared package usb_pkt_pkg holds:
  - PID codes and PID class constants.
  - Status codes.
  - CRC5/CRC16 polynomials, init values and residuals.
- Sub-module rx_crc16: byte-wide CRC16 update, with init and enable inputs.
- CRC5 is inline.

## Test plan
- SETUP token bytes 2D 00 10 -> pid_o 4'hD, token_o 0, pkt_end_o, status 0.
- DATA0 bytes C3 80 06 00 01 00 00 40 00 DD 94 -> 8 data_valid_o strobes carrying 80 06 00 01 00 00 40 00, status 0.
- Zero-length DATA1 bytes 4B 00 00 -> no data_valid_o, status 0.
- ACK D2 -> status 0; ACK with an extra byte (D2 00) -> status 3.
- PID check failure on 2C 00 10 -> status 1; CRC failure on 2D 00 11 -> status 2.
- Abort after C3 80 -> status 4.
- Macro defined, MAX_PAYLOAD=4, data packet with 5 payload bytes -> 4 strobes, then status 5.
- Reset mid-DATA: all outputs return to reset values with no pkt_end_o; the next packet then decodes cleanly.
